// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: converts a Cartesian vector (x, y) into a
// gain-scaled magnitude and a 16-bit binary angle, one micro-rotation per clock.
module cordic_vector #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned ITER  = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   mag_out,
    output logic [15:0]      ang_out
);

    // Two guard bits keep sqrt(2)*K*2^(WIDTH-1) representable.
    localparam int unsigned XW       = WIDTH + 2;
    localparam logic [3:0]  LastIter = 4'(ITER - 1);

    typedef enum logic [1:0] {StIdle, StRotate, StDone} state_e;

    state_e                state_q, state_d;
    logic signed [XW-1:0]  x_q, y_q;
    logic [15:0]           z_q;
    logic [3:0]            cnt_q;
    logic                  zflag_q;
    logic [WIDTH:0]        mag_q;
    logic [15:0]           ang_q;

    logic signed [XW-1:0]  x_ext, y_ext;
    logic signed [XW-1:0]  x_ld, y_ld;
    logic [15:0]           z_ld;
    logic signed [XW-1:0]  x_sh, y_sh;
    logic signed [XW-1:0]  x_nxt, y_nxt;
    logic [15:0]           z_nxt;
    logic [15:0]           atan_i;
    logic                  last_iter;

    // Arctangent table in binary-angle units, indexed by iteration.
    function automatic logic [15:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    atan_lut = 16'd8192;
            4'd1:    atan_lut = 16'd4836;
            4'd2:    atan_lut = 16'd2555;
            4'd3:    atan_lut = 16'd1297;
            4'd4:    atan_lut = 16'd651;
            4'd5:    atan_lut = 16'd326;
            4'd6:    atan_lut = 16'd163;
            4'd7:    atan_lut = 16'd81;
            4'd8:    atan_lut = 16'd41;
            4'd9:    atan_lut = 16'd20;
            4'd10:   atan_lut = 16'd10;
            4'd11:   atan_lut = 16'd5;
            4'd12:   atan_lut = 16'd3;
            4'd13:   atan_lut = 16'd1;
            4'd14:   atan_lut = 16'd1;
            default: atan_lut = 16'd0;
        endcase
    endfunction

    assign x_ext     = {{2{x_in[WIDTH-1]}}, x_in};
    assign y_ext     = {{2{y_in[WIDTH-1]}}, y_in};
    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign mag_out   = mag_q;
    assign ang_out   = ang_q;
    assign last_iter = (cnt_q == LastIter);
    assign atan_i    = atan_lut(cnt_q);

    // Pre-rotate left-half-plane inputs by +/-90 degrees so the iterations converge.
    always_comb begin
        x_ld = x_ext;
        y_ld = y_ext;
        z_ld = 16'h0000;
        if (x_in[WIDTH-1]) begin
            if (!y_in[WIDTH-1]) begin
                x_ld = y_ext;
                y_ld = -x_ext;
                z_ld = 16'h4000;
            end else begin
                x_ld = -y_ext;
                y_ld = x_ext;
                z_ld = 16'hC000;
            end
        end
    end

    // One micro-rotation driving y toward zero; all updates use old values.
    always_comb begin
        x_sh = x_q >>> cnt_q;
        y_sh = y_q >>> cnt_q;
        if (!y_q[XW-1]) begin
            x_nxt = x_q + y_sh;
            y_nxt = y_q - x_sh;
            z_nxt = z_q + atan_i;
        end else begin
            x_nxt = x_q - y_sh;
            y_nxt = y_q + x_sh;
            z_nxt = z_q - atan_i;
        end
    end

    // Next-state logic for the handshake FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (in_valid) state_d = StRotate;
            StRotate: if (last_iter) state_d = StDone;
            StDone:   if (out_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    // Datapath: load on acceptance, iterate in ROTATE, capture result on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            cnt_q   <= '0;
            zflag_q <= 1'b0;
            mag_q   <= '0;
            ang_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        x_q     <= x_ld;
                        y_q     <= y_ld;
                        z_q     <= z_ld;
                        cnt_q   <= '0;
                        zflag_q <= (x_in == '0) && (y_in == '0);
                    end
                end
                StRotate: begin
                    x_q   <= x_nxt;
                    y_q   <= y_nxt;
                    z_q   <= z_nxt;
                    cnt_q <= cnt_q + 4'd1;
                    if (last_iter) begin
                        mag_q <= zflag_q ? '0 : x_nxt[WIDTH:0];
                        ang_q <= zflag_q ? '0 : z_nxt;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_vector.sv
// Self-checking bench for cordic_vector: directed, random, backpressure,
// back-to-back and mid-iteration reset scenarios against a real-arithmetic model.
module tb_cordic_vector;

    localparam int  WIDTH = 16;
    localparam int  ITER  = 12;
    localparam real PI    = 3.14159265358979323846;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  x_in;
    logic [WIDTH-1:0]  y_in;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH:0]    mag_out;
    logic [15:0]       ang_out;

    int  errors = 0;
    int  checks = 0;
    real kf;

    cordic_vector #(.WIDTH(WIDTH), .ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .y_in      (y_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .mag_out   (mag_out),
        .ang_out   (ang_out)
    );

    always #5 clk = ~clk;

    // Reference: ideal magnitude times the CORDIC gain of ITER stages.
    function automatic real model_mag(input int x, input int y);
        real rx, ry;
        rx = real'(x);
        ry = real'(y);
        return kf * $sqrt(rx * rx + ry * ry);
    endfunction

    // Reference: atan2 in binary-angle units (65536 per turn).
    function automatic int model_ang(input int x, input int y);
        real r;
        r = $atan2(real'(y), real'(x)) * 32768.0 / PI;
        return int'(r);
    endfunction

    // Circular distance between an observed binary angle and an expected one.
    function automatic int ang_dist(input logic [15:0] a, input int e);
        logic [15:0] d;
        int          s;
        d = a - e[15:0];
        s = int'($signed(d));
        return (s < 0) ? -s : s;
    endfunction

    function automatic real rabs(input real v);
        return (v < 0.0) ? -v : v;
    endfunction

    // Present one vector, wait for acceptance, then count cycles to out_valid.
    // Leaves the DUT in DONE with out_ready low. lat = -1 on timeout.
    task automatic run_vector(input int x, input int y, output int lat,
                              output logic [WIDTH:0] mag, output logic [15:0] ang);
        int waitc;
        x_in = 16'(x);
        y_in = 16'(y);
        in_valid = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        x_in = 16'($urandom);
        y_in = 16'($urandom);
        lat = 0;
        while (!out_valid && lat < ITER + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        if (!out_valid) lat = -1;
        mag = mag_out;
        ang = ang_out;
    endtask

    task automatic transfer();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid);
        end
        checks++;
        if (mag_out !== '0) begin
            errors++; $display("FAIL reset_mag: got %0d want 0", mag_out);
        end
        checks++;
        if (ang_out !== 16'd0) begin
            errors++; $display("FAIL reset_ang: got %0d want 0", ang_out);
        end
    endtask

    int dir_x   [6] = '{1000, 0,    -1000, -1000, -32768, 0};
    int dir_y   [6] = '{0,    1000, -1000, 0,     -32768, 0};
    int dir_mtol[6] = '{4,    4,    4,     4,     8,      0};
    int dir_atol[6] = '{16,   16,   16,    16,    16,     0};

    task automatic test_directed();
        int              lat;
        logic [WIDTH:0]  mag;
        logic [15:0]     ang;
        real             em;
        int              ea;
        for (int i = 0; i < 6; i++) begin
            run_vector(dir_x[i], dir_y[i], lat, mag, ang);
            em = model_mag(dir_x[i], dir_y[i]);
            ea = model_ang(dir_x[i], dir_y[i]);
            checks++;
            if (lat != ITER) begin
                errors++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, ITER);
            end
            checks++;
            if (rabs(real'(mag) - em) > real'(dir_mtol[i])) begin
                errors++;
                $display("FAIL dir%0d_mag (%0d,%0d): got %0d want %0.1f +/- %0d",
                         i, dir_x[i], dir_y[i], mag, em, dir_mtol[i]);
            end
            checks++;
            if (ang_dist(ang, ea) > dir_atol[i]) begin
                errors++;
                $display("FAIL dir%0d_ang (%0d,%0d): got %0d want %0d +/- %0d",
                         i, dir_x[i], dir_y[i], $signed(ang), ea, dir_atol[i]);
            end
            transfer();
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL dir%0d_after_transfer: in_ready=%b out_valid=%b want 1/0",
                         i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random();
        int                 lat, x, y;
        logic signed [15:0] rx, ry;
        logic [WIDTH:0]     mag;
        logic [15:0]        ang;
        real                em;
        for (int i = 0; i < 24; i++) begin
            do begin
                rx = 16'($urandom);
                ry = 16'($urandom);
                x = int'(rx);
                y = int'(ry);
            end while (real'(x) * real'(x) + real'(y) * real'(y) < 16.0e6);
            run_vector(x, y, lat, mag, ang);
            em = model_mag(x, y);
            checks++;
            if (lat != ITER) begin
                errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, ITER);
            end
            checks++;
            if (rabs(real'(mag) - em) > 12.0) begin
                errors++;
                $display("FAIL rnd%0d_mag (%0d,%0d): got %0d want %0.1f", i, x, y, mag, em);
            end
            checks++;
            if (ang_dist(ang, model_ang(x, y)) > 24) begin
                errors++;
                $display("FAIL rnd%0d_ang (%0d,%0d): got %0d want %0d",
                         i, x, y, $signed(ang), model_ang(x, y));
            end
            transfer();
        end
    endtask

    task automatic test_backpressure();
        int              lat;
        logic [WIDTH:0]  mag;
        logic [15:0]     ang;
        real             em;
        run_vector(-2000, 3000, lat, mag, ang);
        // Offer a second vector while the first result is stalled.
        x_in = 16'd1500;
        y_in = 16'd2500;
        in_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || mag_out !== mag || ang_out !== ang) begin
                errors++;
                $display("FAIL bp_hold c%0d: ov=%b ir=%b mag=%0d ang=%0d want 1/0/%0d/%0d",
                         c, out_valid, in_ready, mag_out, ang_out, mag, ang);
            end
        end
        transfer();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_post_transfer: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL bp_second_accept: in_ready=%b want 0", in_ready);
        end
        lat = 0;
        while (!out_valid && lat < ITER + 8) begin
            @(posedge clk); #1;
            lat++;
        end
        em = model_mag(1500, 2500);
        checks++;
        if (lat != ITER || rabs(real'(mag_out) - em) > 12.0) begin
            errors++;
            $display("FAIL bp_second_result: lat=%0d mag=%0d want %0d/%0.1f", lat, mag_out, ITER, em);
        end
        checks++;
        if (ang_dist(ang_out, model_ang(1500, 2500)) > 24) begin
            errors++;
            $display("FAIL bp_second_ang: got %0d want %0d", $signed(ang_out), model_ang(1500, 2500));
        end
        transfer();
    endtask

    task automatic test_back_to_back();
        int  acc[$];
        int  nres;
        real em;
        int  ea;
        em = model_mag(3000, -4000);
        ea = model_ang(3000, -4000);
        nres = 0;
        x_in = 16'd3000;
        y_in = -16'sd4000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 4 * (ITER + 2) + 2; c++) begin
            checks++;
            if (in_ready === 1'b1 && out_valid === 1'b1) begin
                errors++; $display("FAIL b2b_exclusive c%0d: in_ready and out_valid both 1", c);
            end
            if (in_ready === 1'b1) acc.push_back(c);
            if (out_valid === 1'b1) begin
                nres++;
                checks++;
                if (rabs(real'(mag_out) - em) > 12.0 || ang_dist(ang_out, ea) > 24) begin
                    errors++;
                    $display("FAIL b2b_result c%0d: mag=%0d ang=%0d want %0.1f/%0d",
                             c, mag_out, $signed(ang_out), em, ea);
                end
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (acc.size() < 4 || nres < 3) begin
            errors++;
            $display("FAIL b2b_count: accepts=%0d results=%0d want >=4/>=3", acc.size(), nres);
        end
        for (int k = 1; k < acc.size(); k++) begin
            checks++;
            if (acc[k] - acc[k-1] != ITER + 2) begin
                errors++;
                $display("FAIL b2b_period%0d: got %0d want %0d", k, acc[k] - acc[k-1], ITER + 2);
            end
        end
        for (int c = 0; c < 2 * ITER && !in_ready; c++) begin
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int              lat;
        logic [WIDTH:0]  mag;
        logic [15:0]     ang;
        int              spurious;
        x_in = 16'd4000;
        y_in = 16'd1000;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || mag_out !== '0 || ang_out !== 16'd0) begin
            errors++;
            $display("FAIL midrst_values: ir=%b ov=%b mag=%0d ang=%0d want 1/0/0/0",
                     in_ready, out_valid, mag_out, ang_out);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        spurious = 0;
        for (int c = 0; c < ITER + 4; c++) begin
            if (out_valid !== 1'b0) spurious++;
            @(posedge clk); #1;
        end
        checks++;
        if (spurious != 0) begin
            errors++; $display("FAIL midrst_spurious: got %0d valid cycles want 0", spurious);
        end
        run_vector(2500, -1500, lat, mag, ang);
        checks++;
        if (lat != ITER || rabs(real'(mag) - model_mag(2500, -1500)) > 12.0
            || ang_dist(ang, model_ang(2500, -1500)) > 24) begin
            errors++;
            $display("FAIL midrst_recovery: lat=%0d mag=%0d ang=%0d want %0d/%0.1f/%0d", lat, mag,
                     $signed(ang), ITER, model_mag(2500, -1500), model_ang(2500, -1500));
        end
        transfer();
    endtask

    initial begin
        kf = 1.0;
        for (int i = 0; i < ITER; i++) kf = kf * $sqrt(1.0 + 2.0 ** (-2.0 * real'(i)));
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        x_in = '0;
        y_in = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit in case a handshake never completes.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish (errors=%0d checks=%0d)", errors, checks);
        $fatal(1);
    end

endmodule
